prim_generic_ram_1p_scrub: RTL and testbench
============================================

# prim_generic_ram_1p_scrub

Synchronous single-port SRAM model with a hardware zero-initialisation sweep after reset, grant/valid handshake, optional output pipeline register and per-group parity. It is the successor of the plain generic 1-port RAM for I3C-core buffers (TTI/queue storage) that need known contents after reset and a read-valid strobe instead of a fixed implicit latency. Storage is a behavioural array, and the block is technology-agnostic.

## Interface
- Width, 32, data word width in bits.
- Depth, 128, number of words; any value ≥ 2, not restricted to powers of two.
- DataBitsPerMask, 8, data bits per write-mask group; Width % DataBitsPerMask must be 0, checked by an init-time assertion.
- OutputReg, 0, extra read pipeline stage (0 or 1).
- ZeroInit, 1, 1 enables the post-reset zeroing sweep; 0 means no sweep and memory contents are undefined.
- Aw (localparam), $clog2(Depth), address width.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- req_i  in  1  access request.
- gnt_o  out  1  request accepted this cycle; equals init_done_o.
- write_i  in  1  1 = write, 0 = read.
- addr_i  in  Aw  word address.
- wdata_i  in  Width  write data.
- wmask_i  in  Width  full bit mask, reduced per group.
- rvalid_o  out  1  rdata_o/rerror_o valid for one cycle.
- rdata_o  out  Width  read data, held between reads.
- rerror_o  out  1  parity mismatch on current read (see Configuration).
- init_done_o  out  1  sweep finished; memory usable.

## Operation
- Reset values: gnt_o=0 (or 1 if ZeroInit=0), rvalid_o=0, rdata_o=0, rerror_o=0, init_done_o=ZeroInit?0:1, pipeline valid bits 0, sweep counter 0.
- FSM with two states: INIT and READY. Reset enters INIT when ZeroInit=1, otherwise READY.
- INIT: on each clock, write all-zero data (and zero parity) to address cnt, then increment cnt. After writing Depth-1, the FSM goes to READY. The sweep takes exactly Depth cycles. req_i is ignored and not granted.
- READY: gnt_o=1. An access is accepted when req_i && gnt_o.
- Write: group k is written only if all DataBitsPerMask bits of its wmask_i slice are 1. A partial group is not written, and an assertion fires on mixed groups. Writes never change rdata_o and never pulse rvalid_o.
- Read: mem[addr_i] is captured. rvalid_o pulses with the data after the latency given in Timing. Back-to-back reads sustain one result per cycle.
- Address ≥ Depth, non-power-of-two Depth: a write is dropped. A read returns 0 with rvalid_o=1 and rerror_o=0.
- Read-after-write to the same address on consecutive cycles returns the new data.
- Reset asserted mid-sweep or mid-read: all state returns to reset values immediately, in-flight reads are discarded with no rvalid_o, and the sweep restarts from address 0. Array contents are not reset asynchronously.

## Timing
- Read accepted at edge N:
  - OutputReg=0: rdata_o/rvalid_o are valid after edge N+1.
  - OutputReg=1: rdata_o/rvalid_o are valid after edge N+2.
- rvalid_o is high for exactly one cycle per accepted read. rdata_o holds its value until the next read result.
- With ZeroInit=1, init_done_o and gnt_o rise after the Depth-th rising edge following rst_ni deassertion.
- gnt_o is purely a function of FSM state and has no combinational path from req_i.

## Configuration
- I3C_RAM_PARITY_EN defined:
  - Each mask group stores one extra even-parity bit, written with its group.
  - On read, parity is recomputed per group. rerror_o is set alongside rvalid_o if any group mismatches.
  - The sweep writes correct parity (0).
- I3C_RAM_PARITY_EN undefined: no parity storage exists and rerror_o is tied to 0.
- Ports are identical in both builds.

## Test plan
- Sweep, Depth=16, ZeroInit=1: release reset. Require gnt_o=0 for 16 cycles, then gnt_o=init_done_o=1. A read of addr 5 returns 0x00000000.
- Masked write: write 0x11223344 to addr 3, then 0xAABBCCDD with wmask 0x00FF00FF. The read returns 0x11BB33DD. Mask 0x0000000F then leaves the word unchanged and fires the MaskCheck assertion.
- Latency, OutputReg=1: write 0x1,0x2,0x3 to addrs 1..3, then issue back-to-back reads at edges N..N+2. Require rvalid_o high at N+2..N+4 with data 0x1,0x2,0x3. With OutputReg=0, the same reads return at N+1..N+3.
- Reset mid-sweep, Depth=16: assert rst_ni low at sweep cycle 7. After release, init_done_o stays 0 for a full 16 cycles. No rvalid_o occurs.
- Out of range, Depth=12: write 0xDEADBEEF to addr 13, then read addr 13. Require rdata_o=0 and rvalid_o=1, with addr 0..11 unchanged.
- Parity (I3C_RAM_PARITY_EN): write 0xFFFFFFFF to addr 2, force-flip the stored parity bit of group 1, then read. Require rerror_o=1 with rvalid_o. A read of addr 4 gives rerror_o=0. Without the macro, rerror_o is always 0.

Source files
------------

// File: rtl/prim_generic_ram_1p_scrub.sv
// prim_generic_ram_1p_scrub
//   Single-port behavioural SRAM for I3C-core buffers. After reset it sweeps
//   zeros into every word and only then grants requests. A read returns its
//   data with a one-cycle rvalid_o strobe, and rdata_o holds between reads.
//   Writes are masked per group of DataBitsPerMask bits. A group is written
//   only if its whole mask slice is set.
//
//   Optional feature macro: I3C_RAM_PARITY_EN
//     defined   : one even-parity bit per mask group, checked on read (rerror_o)
//     undefined : no parity storage, rerror_o stays 0
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   req_i        access request
//   gnt_o        request accepted this cycle (equals init_done_o)
//   write_i      1 = write, 0 = read
//   addr_i       word address (Aw bits)
//   wdata_i      write data
//   wmask_i      bit mask, reduced per group
//   rvalid_o     rdata_o / rerror_o valid for this cycle
//   rdata_o      read data, held between reads
//   rerror_o     parity mismatch on the current read
//   init_done_o  zeroing sweep finished

module prim_generic_ram_1p_scrub #(
  parameter int Width           = 32,
  parameter int Depth           = 128,
  parameter int DataBitsPerMask = 8,
  parameter int OutputReg       = 0,
  parameter int ZeroInit        = 1,
  localparam int Aw             = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic             write_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] wmask_i,
  output logic             rvalid_o,
  output logic [Width-1:0] rdata_o,
  output logic             rerror_o,
  output logic             init_done_o
);

  localparam int NumGroups = Width / DataBitsPerMask;

  typedef enum logic {INIT, READY} state_e;
  localparam state_e ResetState = (ZeroInit != 0) ? INIT : READY;

  state_e        state;
  logic [Aw-1:0] cnt;
  logic          init_done;

  logic [Width-1:0] mem [Depth];

  logic                 in_range, accept, wr_en, rd_en;
  logic [NumGroups-1:0] group_en, mask_ok;
  logic [Width-1:0]     rd_data;
  logic                 rd_err;

  assign gnt_o       = init_done;
  assign init_done_o = init_done;

  // Extra top bit so a power-of-two Depth still compares correctly.
  assign in_range = {1'b0, addr_i} < (Aw+1)'(Depth);
  assign accept   = req_i & init_done;
  assign wr_en    = accept & write_i & in_range;
  assign rd_en    = accept & ~write_i;
  assign rd_data  = in_range ? mem[addr_i] : '0;

  always_comb begin
    group_en = '0;
    mask_ok  = '0;
    for (int unsigned g = 0; g < NumGroups; g++) begin
      group_en[g] = &wmask_i[g*DataBitsPerMask +: DataBitsPerMask];
      mask_ok[g]  = group_en[g] | ~(|wmask_i[g*DataBitsPerMask +: DataBitsPerMask]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ResetState;
      cnt       <= '0;
      init_done <= (ZeroInit == 0);
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == Aw'(Depth - 1)) begin
        state     <= READY;
        init_done <= 1'b1;
        cnt       <= '0;
      end
    end
  end

`ifdef I3C_RAM_PARITY_EN
  logic [NumGroups-1:0] par_mem [Depth];
  logic [NumGroups-1:0] wpar, rpar;

  always_comb begin
    wpar = '0;
    rpar = '0;
    for (int unsigned g = 0; g < NumGroups; g++) begin
      wpar[g] = ^wdata_i[g*DataBitsPerMask +: DataBitsPerMask];
      rpar[g] = ^rd_data[g*DataBitsPerMask +: DataBitsPerMask];
    end
  end

  assign rd_err = in_range & (|(rpar ^ par_mem[addr_i]));
`else
  assign rd_err = 1'b0;
`endif

  // Storage has no reset; the sweep provides the known contents.
  always_ff @(posedge clk_i) begin
    if (state == INIT) begin
      mem[cnt] <= '0;
`ifdef I3C_RAM_PARITY_EN
      par_mem[cnt] <= '0;
`endif
    end else if (wr_en) begin
      for (int unsigned g = 0; g < NumGroups; g++) begin
        if (group_en[g]) begin
          mem[addr_i][g*DataBitsPerMask +: DataBitsPerMask] <=
            wdata_i[g*DataBitsPerMask +: DataBitsPerMask];
`ifdef I3C_RAM_PARITY_EN
          par_mem[addr_i][g] <= wpar[g];
`endif
        end
      end
    end
  end

  // Read pipeline: array capture, optional extra stage, then output register.
  logic             s1_valid, s1_err;
  logic [Width-1:0] s1_data;
  logic             last_valid, last_err;
  logic [Width-1:0] last_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_en;
      if (rd_en) begin
        s1_data <= rd_data;
        s1_err  <= rd_err;
      end
    end
  end

  if (OutputReg != 0) begin : g_out_reg
    logic             s2_valid, s2_err;
    logic [Width-1:0] s2_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s2_valid <= 1'b0;
        s2_err   <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
          s2_err  <= s1_err;
        end
      end
    end

    assign last_valid = s2_valid;
    assign last_err   = s2_err;
    assign last_data  = s2_data;
  end else begin : g_no_out_reg
    assign last_valid = s1_valid;
    assign last_err   = s1_err;
    assign last_data  = s1_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      rerror_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= last_valid;
      rerror_o <= last_valid & last_err;
      if (last_valid) rdata_o <= last_data;
    end
  end

`ifndef SYNTHESIS
  WidthDivisible: assert property (@(posedge clk_i) (Width % DataBitsPerMask) == 0);
  MaskCheck: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_i && gnt_o && write_i) |-> (&mask_ok));
`endif

endmodule

// File: tb/tb_prim_generic_ram_1p_scrub.sv
// Bench for prim_generic_ram_1p_scrub: two instances (OutputReg 0 and 1,
// Depth 12) share one stimulus stream and are compared every cycle against
// a word-array reference with latency arithmetic.

module tb_prim_generic_ram_1p_scrub;

  localparam int DEPTH = 12;
  localparam int NCYC  = 4096;

  typedef struct {
    bit          r;
    bit          w;
    int          a;
    logic [31:0] d;
    logic [31:0] m;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n, req, write;
  logic [3:0]  addr;
  logic [31:0] wdata, wmask;
  logic        gnt0, rvalid0, rerror0, done0;
  logic        gnt1, rvalid1, rerror1, done1;
  logic [31:0] rdata0, rdata1;

  always #5 clk = ~clk;

  prim_generic_ram_1p_scrub #(.Width(32), .Depth(DEPTH), .DataBitsPerMask(8),
    .OutputReg(0), .ZeroInit(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt0), .write_i(write),
    .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask), .rvalid_o(rvalid0),
    .rdata_o(rdata0), .rerror_o(rerror0), .init_done_o(done0));

  prim_generic_ram_1p_scrub #(.Width(32), .Depth(DEPTH), .DataBitsPerMask(8),
    .OutputReg(1), .ZeroInit(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt1), .write_i(write),
    .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask), .rvalid_o(rvalid1),
    .rdata_o(rdata1), .rerror_o(rerror1), .init_done_o(done1));

  // Reference state
  logic [31:0] ref_mem [DEPTH];
  logic [3:0]  perr [DEPTH];
  bit          rd_v [NCYC];
  logic [31:0] rd_d [NCYC];
  bit          rd_e [NCYC];
  logic [31:0] hold [2];
  int          cyc, since;
  logic [35:0] exp_o [2];   // {gnt, init_done, rvalid, rerror, rdata}
  logic [35:0] obs_o [2];
  int          n_assert, n_fail;

  task automatic drive(input bit r, input bit w, input int a,
                       input logic [31:0] d, input logic [31:0] m);
    req = r; write = w; addr = 4'(a); wdata = d; wmask = m;
  endtask

  function automatic logic [31:0] rand_mask();
    logic [31:0] m = '0;
    for (int g = 0; g < 4; g++) if ($urandom_range(0, 1) == 1) m[g*8 +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    since = 0;
    for (int k = 0; k < NCYC; k++) rd_v[k] = 1'b0;
    hold[0] = '0;
    hold[1] = '0;
  endtask

  // One clock: update the reference for the edge, then sample both DUTs.
  task automatic step();
    bit acc, v;
    int src;
    acc = (rst_n === 1'b1) && req && (since >= DEPTH);
    if (cyc >= NCYC - 2) begin
      $display("FAIL cycle_budget: cyc=%0d, need < %0d", cyc, NCYC - 2);
      $fatal(1);
    end
    @(posedge clk);
    cyc++;
    if (rst_n === 1'b1) begin
      if (since < DEPTH) begin
        ref_mem[since] = '0;
        perr[since]    = '0;
      end else if (acc && write) begin
        if (addr < DEPTH)
          for (int g = 0; g < 4; g++)
            if (wmask[g*8 +: 8] == 8'hFF) begin
              ref_mem[addr][g*8 +: 8] = wdata[g*8 +: 8];
              perr[addr][g] = 1'b0;
            end
      end else if (acc) begin
        rd_v[cyc] = 1'b1;
        rd_d[cyc] = (addr < DEPTH) ? ref_mem[addr] : 32'h0;
        rd_e[cyc] = (addr < DEPTH) && (|perr[addr]);
      end
      if (since < DEPTH) since++;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      src = cyc - (i + 1);
      v = (src >= 0) && rd_v[src];
      if (v) hold[i] = rd_d[src];
      exp_o[i] = {since >= DEPTH, since >= DEPTH, v, v && rd_e[src], hold[i]};
    end
    obs_o[0] = {gnt0, done0, rvalid0, rerror0, rdata0};
    obs_o[1] = {gnt1, done1, rvalid1, rerror1, rdata1};
  endtask

  task automatic test_reset();
    do_reset();
    drive(1, 0, 2, '0, '0);
    for (int k = 0; k < 3; k++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        n_assert++;
        if (obs_o[i] !== exp_o[i]) begin
          n_fail++;
          $display("FAIL reset dut%0d cyc %0d: got %h, need %h", i, cyc, obs_o[i], exp_o[i]);
        end
      end
    end
  endtask

  task automatic test_sweep();
    rst_n = 1'b1;
    drive(1, 0, 5, '0, '0);   // requested during the sweep: must not be granted
    for (int k = 0; k < DEPTH + 5; k++) begin
      if (k == DEPTH + 1) drive(0, 0, 0, '0, '0);
      step();
      for (int i = 0; i < 2; i++) begin
        n_assert++;
        if (obs_o[i] !== exp_o[i]) begin
          n_fail++;
          $display("FAIL sweep dut%0d cyc %0d: got %h, need %h", i, cyc, obs_o[i], exp_o[i]);
        end
      end
    end
    n_assert++;
    if ({gnt0, done0, gnt1, done1, rdata0, rdata1} !== {4'hF, 64'h0}) begin
      n_fail++;
      $display("FAIL sweep_end: got gnt/done %b%b%b%b data %h %h, need 1111 0 0",
               gnt0, done0, gnt1, done1, rdata0, rdata1);
    end
  endtask

  task automatic test_random_rw();
    for (int k = 0; k < 80; k++) begin
      if (k < 76)
        drive($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, DEPTH - 1), $urandom, rand_mask());
      else
        drive(0, 0, 0, '0, '0);
      step();
      for (int i = 0; i < 2; i++) begin
        n_assert++;
        if (obs_o[i] !== exp_o[i]) begin
          n_fail++;
          $display("FAIL random_rw dut%0d cyc %0d: got %h, need %h", i, cyc, obs_o[i], exp_o[i]);
        end
      end
    end
  endtask

  task automatic test_masked();
    op_t ops[$];
    ops.push_back('{1'b1, 1'b1, 3, 32'h11223344, 32'hFFFFFFFF});
    ops.push_back('{1'b1, 1'b1, 3, 32'hAABBCCDD, 32'h00FF00FF});
    ops.push_back('{1'b1, 1'b1, 3, 32'h55555555, 32'h00000000});
    ops.push_back('{1'b1, 1'b0, 3, 32'h0, 32'h0});
    for (int k = 0; k < 4; k++) ops.push_back('{1'b0, 1'b0, 0, 32'h0, 32'h0});
    foreach (ops[k]) begin
      drive(ops[k].r, ops[k].w, ops[k].a, ops[k].d, ops[k].m);
      step();
      for (int i = 0; i < 2; i++) begin
        n_assert++;
        if (obs_o[i] !== exp_o[i]) begin
          n_fail++;
          $display("FAIL masked dut%0d cyc %0d: got %h, need %h", i, cyc, obs_o[i], exp_o[i]);
        end
      end
    end
    n_assert++;
    if (rdata0 !== 32'h11BB33DD || rdata1 !== 32'h11BB33DD) begin
      n_fail++;
      $display("FAIL masked_word: got %h %h, need 11bb33dd", rdata0, rdata1);
    end
  endtask

  task automatic test_back_to_back();
    op_t ops[$];
    int issue;
    int first [2];
    first[0] = -1;
    first[1] = -1;
    issue = -1;
    for (int a = 1; a <= 3; a++) ops.push_back('{1'b1, 1'b1, a, 32'(a), 32'hFFFFFFFF});
    for (int a = 1; a <= 3; a++) ops.push_back('{1'b1, 1'b0, a, 32'h0, 32'h0});
    for (int k = 0; k < 4; k++) ops.push_back('{1'b0, 1'b0, 0, 32'h0, 32'h0});
    ops.push_back('{1'b1, 1'b1, 7, 32'h77, 32'hFFFFFFFF});
    ops.push_back('{1'b1, 1'b0, 7, 32'h0, 32'h0});
    for (int k = 0; k < 3; k++) ops.push_back('{1'b0, 1'b0, 0, 32'h0, 32'h0});
    foreach (ops[k]) begin
      drive(ops[k].r, ops[k].w, ops[k].a, ops[k].d, ops[k].m);
      step();
      if (k == 3) issue = cyc;
      if (issue >= 0 && first[0] < 0 && rvalid0 === 1'b1) first[0] = cyc;
      if (issue >= 0 && first[1] < 0 && rvalid1 === 1'b1) first[1] = cyc;
      for (int i = 0; i < 2; i++) begin
        n_assert++;
        if (obs_o[i] !== exp_o[i]) begin
          n_fail++;
          $display("FAIL back_to_back dut%0d cyc %0d: got %h, need %h", i, cyc, obs_o[i], exp_o[i]);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      n_assert++;
      if (first[i] - issue !== i + 1) begin
        n_fail++;
        $display("FAIL latency dut%0d: got %0d edges, need %0d", i, first[i] - issue, i + 1);
      end
    end
  endtask

  task automatic test_out_of_range();
    op_t ops[$];
    ops.push_back('{1'b1, 1'b1, 13, 32'hDEADBEEF, 32'hFFFFFFFF});
    ops.push_back('{1'b1, 1'b1, 12, 32'hCAFEF00D, 32'hFFFFFFFF});
    ops.push_back('{1'b1, 1'b0, 13, 32'h0, 32'h0});
    for (int a = 0; a < DEPTH; a++) ops.push_back('{1'b1, 1'b0, a, 32'h0, 32'h0});
    ops.push_back('{1'b1, 1'b0, 15, 32'h0, 32'h0});
    for (int k = 0; k < 3; k++) ops.push_back('{1'b0, 1'b0, 0, 32'h0, 32'h0});
    foreach (ops[k]) begin
      drive(ops[k].r, ops[k].w, ops[k].a, ops[k].d, ops[k].m);
      step();
      for (int i = 0; i < 2; i++) begin
        n_assert++;
        if (obs_o[i] !== exp_o[i]) begin
          n_fail++;
          $display("FAIL out_of_range dut%0d cyc %0d: got %h, need %h", i, cyc, obs_o[i], exp_o[i]);
        end
      end
    end
  endtask

`ifdef I3C_RAM_PARITY_EN
  task automatic test_parity();
    op_t ops[$];
    drive(1, 1, 2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step();
    drive(0, 0, 0, '0, '0);
    step();
    dut0.par_mem[2][1] = ~dut0.par_mem[2][1];
    dut1.par_mem[2][1] = ~dut1.par_mem[2][1];
    perr[2][1] = 1'b1;
    ops.push_back('{1'b1, 1'b0, 2, 32'h0, 32'h0});
    ops.push_back('{1'b1, 1'b0, 4, 32'h0, 32'h0});
    ops.push_back('{1'b1, 1'b1, 2, 32'h0000FF00, 32'h0000FF00});
    ops.push_back('{1'b1, 1'b0, 2, 32'h0, 32'h0});
    for (int k = 0; k < 3; k++) ops.push_back('{1'b0, 1'b0, 0, 32'h0, 32'h0});
    foreach (ops[k]) begin
      drive(ops[k].r, ops[k].w, ops[k].a, ops[k].d, ops[k].m);
      step();
      for (int i = 0; i < 2; i++) begin
        n_assert++;
        if (obs_o[i] !== exp_o[i]) begin
          n_fail++;
          $display("FAIL parity dut%0d cyc %0d: got %h, need %h", i, cyc, obs_o[i], exp_o[i]);
        end
      end
    end
  endtask
`endif

  task automatic test_reset_mid_flight();
    drive(1, 0, 1, '0, '0);
    step();
    drive(1, 0, 2, '0, '0);
    step();
    do_reset();               // both reads still inside the pipelines
    drive(1, 0, 3, '0, '0);
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 1) rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
        n_assert++;
        if (obs_o[i] !== exp_o[i]) begin
          n_fail++;
          $display("FAIL reset_mid_read dut%0d cyc %0d: got %h, need %h", i, cyc, obs_o[i], exp_o[i]);
        end
      end
    end
    for (int k = 0; k < 5; k++) step();   // now at sweep cycle 7
    do_reset();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < DEPTH + 3; k++) begin
      if (k == DEPTH + 1) drive(0, 0, 0, '0, '0);
      step();
      for (int i = 0; i < 2; i++) begin
        n_assert++;
        if (obs_o[i] !== exp_o[i]) begin
          n_fail++;
          $display("FAIL reset_mid_sweep dut%0d cyc %0d: got %h, need %h", i, cyc, obs_o[i], exp_o[i]);
        end
      end
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    since    = 0;
    rst_n    = 1'b0;
    req      = 1'b0;
    write    = 1'b0;
    addr     = '0;
    wdata    = '0;
    wmask    = '0;
    for (int a = 0; a < DEPTH; a++) begin
      ref_mem[a] = '0;
      perr[a]    = '0;
    end
    test_reset();
    test_sweep();
    test_random_rw();
    test_masked();
    test_back_to_back();
    test_out_of_range();
`ifdef I3C_RAM_PARITY_EN
    test_parity();
`endif
    test_reset_mid_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
